// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit pseudo-random sequence generator and checker.
package lfsr_pkg;

  // Tap mask and polarity shared by both ends of the link so they agree.
  localparam logic [7:0] LFSR8_TAPS   = 8'hAA;
  localparam bit         LFSR8_INVERT = 1'b1;

  // Checker synchronisation state.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit prediction: XOR (or XNOR) of the tapped history bits.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(LFSR8_TAPS),
  parameter bit               INVERT = LFSR8_INVERT
) (
  input  logic [WIDTH-1:0] h_i,
  output logic             p_o
);

  // Reduction over the masked history, then optional inversion.
  always_comb begin
    p_o = INVERT ^ (^(h_i & TAPS));
  end

endmodule

// File: rtl/prbs8_checker.sv
// Serial receive-side checker: self-synchronises to the pseudo-random stream,
// then free-runs its reference, counts bit errors and drops lock on error bursts.
module prbs8_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR8_TAPS),
  parameter bit               INVERT       = LFSR8_INVERT,
  parameter int unsigned      LOCK_MATCHES = 16,
  parameter int unsigned      WIN_LEN      = 64,
  parameter int unsigned      LOSS_ERRS    = 8,
  parameter int unsigned      CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             stuck
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned WBITS_W = $clog2(WIN_LEN + 1);
  localparam int unsigned WERRS_W = $clog2(LOSS_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_MATCHES - 1);
  localparam logic [WBITS_W-1:0] WIN_WRAP   = WBITS_W'(WIN_LEN);
  localparam logic [WERRS_W-1:0] ERR_LIMIT  = WERRS_W'(LOSS_ERRS);
  // The generator can never leave this pattern, so it is not a valid lock point.
  localparam logic [WIDTH-1:0]   LOCKUP     = INVERT ? '1 : '0;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WBITS_W-1:0] win_bits_q, win_bits_d, win_bits_inc;
  logic [WERRS_W-1:0] win_errs_q, win_errs_d, win_errs_inc;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               stuck_q, stuck_d;
  logic               pred;
  logic               mismatch;

  lfsr_predict #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .INVERT(INVERT)
  ) u_predict (
    .h_i(h_q),
    .p_o(pred)
  );

  // Next-state: history shift, sync/lock FSM, window and error counters.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    fill_d       = fill_q;
    match_d      = match_q;
    win_bits_d   = win_bits_q;
    win_errs_d   = win_errs_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    mismatch     = (in_bit != pred);
    win_bits_inc = win_bits_q + WBITS_W'(1);
    win_errs_inc = win_errs_q + WERRS_W'(mismatch);

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // Load received bits so the reference synchronises to the stream.
          h_d = {h_q[WIDTH-2:0], in_bit};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
          end else if (!mismatch && (h_q != LOCKUP)) begin
            if (match_q == MATCH_LAST) begin
              state_d    = LOCKED;
              match_d    = '0;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so one bit error is counted only once.
          h_d = {h_q[WIDTH-2:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end
          // Loss takes priority over a window wrap on the same bit.
          if (win_errs_inc == ERR_LIMIT) begin
            state_d    = HUNT;
            fill_d     = '0;
            match_d    = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_inc == WIN_WRAP) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_inc;
            win_errs_d = win_errs_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear beats a same-cycle increment.
    if (clr_cnt) begin
      err_count_d = '0;
    end

    stuck_d = (h_d == LOCKUP);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      stuck_q     <= stuck_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    locked    = (state_q == LOCKED);
    err_pulse = err_pulse_q;
    err_count = err_count_q;
    stuck     = stuck_q;
  end

endmodule

// File: tb/tb_prbs8_checker.sv
// Directed/randomised bench for prbs8_checker with a behavioural reference model.
module tb_prbs8_checker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        stuck;

  int vectors     = 0;
  int miscompares = 0;
  int pulses_seen = 0;

  prbs8_checker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .stuck    (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator: past bits, newest first; b[n] = ~(b[n-8]^b[n-6]^b[n-4]^b[n-2]).
  bit gen_past[$];

  function automatic bit next_gen();
    bit nb;
    nb = ~(gen_past[1] ^ gen_past[3] ^ gen_past[5] ^ gen_past[7]);
    gen_past.push_front(nb);
    void'(gen_past.pop_back());
    return nb;
  endfunction

  // Reference model: spec rules on plain integers, history as a queue of past bits.
  bit m_past[$];
  bit m_locked;
  int m_fill, m_run, m_win_bits, m_win_errs, m_errs;
  bit m_pulse, m_stuck;

  function automatic void model_reset();
    m_past.delete();
    for (int i = 0; i < 8; i++) m_past.push_back(1'b0);
    m_locked   = 1'b0;
    m_fill     = 0;
    m_run      = 0;
    m_win_bits = 0;
    m_win_errs = 0;
    m_errs     = 0;
    m_pulse    = 1'b0;
    m_stuck    = 1'b0;
  endfunction

  function automatic bit all_ones();
    for (int i = 0; i < 8; i++) if (!m_past[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit c);
    bit pred;
    bit was_stuck;
    m_pulse = 1'b0;
    if (v) begin
      pred      = ~(m_past[1] ^ m_past[3] ^ m_past[5] ^ m_past[7]);
      was_stuck = all_ones();
      if (!m_locked) begin
        m_past.push_front(b);
        void'(m_past.pop_back());
        if (m_fill < 8) m_fill++;
        else if (b == pred && !was_stuck) m_run++;
        else m_run = 0;
        if (m_run == 16) begin
          m_locked   = 1'b1;
          m_run      = 0;
          m_win_bits = 0;
          m_win_errs = 0;
        end
      end else begin
        m_past.push_front(pred);
        void'(m_past.pop_back());
        m_win_bits++;
        if (b != pred) begin
          m_pulse = 1'b1;
          if (m_errs < 65535) m_errs++;
          m_win_errs++;
        end
        if (m_win_errs == 8) begin
          m_locked   = 1'b0;
          m_fill     = 0;
          m_run      = 0;
          m_win_bits = 0;
          m_win_errs = 0;
        end else if (m_win_bits == 64) begin
          m_win_bits = 0;
          m_win_errs = 0;
        end
      end
    end
    if (c) m_errs = 0;
    m_stuck = all_ones();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    model_step(v, b, c);
    if (err_pulse === 1'b1) pulses_seen++;
    check("locked", 32'(locked), 32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_count", 32'(err_count), 32'(m_errs));
    check("stuck", 32'(stuck), 32'(m_stuck));
  endtask

  task automatic feed_clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, next_gen(), 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clr_cnt  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) gen_past.push_back(1'b0);

    // Reset state.
    do_reset();
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_stuck", 32'(stuck), 0);

    // Clean lock: 8 fill bits plus 16 matches.
    feed_clean(23);
    check("lock_not_yet", 32'(locked), 0);
    feed_clean(1);
    check("lock_at_24", 32'(locked), 1);
    feed_clean(976);
    check("clean_err_count", 32'(err_count), 0);
    check("clean_locked", 32'(locked), 1);

    // Single error: counted once, no error multiplication.
    pulses_seen = 0;
    step(1'b1, ~next_gen(), 1'b0);
    feed_clean(30);
    check("single_pulses", 32'(pulses_seen), 1);
    check("single_count", 32'(err_count), 1);
    check("single_locked", 32'(locked), 1);

    // Loss of lock: align to a fresh window, clear the count, then 8 errors.
    for (int i = 0; i < 64 && m_win_bits != 0; i++) feed_clean(1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_idle", 32'(err_count), 0);
    for (int i = 0; i < 7; i++) step(1'b1, ~next_gen(), 1'b0);
    check("loss_not_yet", 32'(locked), 1);
    step(1'b1, ~next_gen(), 1'b0);
    check("loss_locked", 32'(locked), 0);
    check("loss_count", 32'(err_count), 8);
    feed_clean(23);
    check("relock_not_yet", 32'(locked), 0);
    feed_clean(1);
    check("relock_at_24", 32'(locked), 1);

    // Gaps: lock timing counts valid bits only.
    do_reset();
    vcount = 0;
    for (int i = 0; i < 400 && vcount < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        step(1'b1, next_gen(), 1'b0);
        vcount++;
        check("gap_lock_timing", 32'(locked), 32'(vcount >= 24));
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    check("gap_bits_done", 32'(vcount), 40);
    step(1'b1, ~next_gen(), 1'b0);
    check("gap_err_count", 32'(err_count), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, ~next_gen(), 1'b1);
    check("clr_with_err", 32'(err_count), 0);
    check("clr_err_pulse", 32'(err_pulse), 1);
    feed_clean(10);

    // Asynchronous reset while locked: no clock edge needed.
    step(1'b1, ~next_gen(), 1'b0);
    check("pre_rst_locked", 32'(locked), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_locked", 32'(locked), 0);
    check("async_err_count", 32'(err_count), 0);
    check("async_stuck", 32'(stuck), 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones input: lock-up pattern detected, never locks.
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (i == 7) check("ones_stuck_7", 32'(stuck), 0);
      if (i == 8) check("ones_stuck_8", 32'(stuck), 1);
      check("ones_no_lock", 32'(locked), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Serial receive-side checker for the team's 8-bit pseudo-random generator sequence: takes one bit per valid cycle and self-synchronises to the stream.
- Once locked, predicts every following bit, flags and counts mismatches, and drops lock when the error density is too high.
- Sits at the far end of a link or loopback under test; its error count is the pass/fail figure for BER and loopback checks.

Parameters:
- WIDTH, 8, history length in bits (equals the generator register width).
- TAPS, 8'hAA, tap mask over history; bit i set means h[i] feeds the prediction (h[0] is the newest bit).
- INVERT, 1, 1 means prediction is XNOR of the taps, 0 means XOR.
- LOCK_MATCHES, 16, consecutive correct predictions required to declare lock.
- WIN_LEN, 64, loss-of-lock observation window, in valid bits.
- LOSS_ERRS, 8, errors within one window that force loss of lock.
- CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bit is sampled on cycles where this is 1.
- in_bit  in  1  received serial bit.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  1 while in the LOCKED state.
- err_pulse  out  1  one-cycle pulse for each mismatching bit while locked.
- err_count  out  CNT_W  saturating count of errors since reset or clr_cnt.
- stuck  out  1  history currently holds the lock-up pattern.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - history = 0, fill counter = 0, match counter = 0, window counters = 0, state = HUNT.
  - Outputs: locked=0, err_pulse=0, err_count=0, stuck=0.
  - A reset in the middle of a lock takes effect immediately; there is no drain.
- Prediction: p = INVERT XOR (XOR over all i with TAPS[i]=1 of h[i]).
- History update: on each valid bit, h shifts left by one with a new h[0]. The source of the new h[0] depends on the state (below).
- in_valid=0 cycles: no state, counter or history change; err_pulse=0.
- Lock-up pattern: all-ones if INVERT=1, all-zeros if INVERT=0. stuck is the registered result of comparing history against it.
- States: HUNT, LOCKED.
- HUNT:
  - The new h[0] is in_bit, so the checker self-synchronises.
  - The fill counter counts up to WIDTH valid bits. No comparisons are made until history is full.
  - Once full, for each valid bit:
    - in_bit==p and history is not the lock-up pattern: match counter increments.
    - Otherwise: match counter resets to 0.
  - When the match counter reaches LOCK_MATCHES, the state moves to LOCKED and locked rises on the cycle after that bit.
  - Window counters are cleared on entry to LOCKED.
  - No errors are counted in HUNT.
- LOCKED:
  - The new h[0] is p, so the reference free-runs and each bit error counts exactly once.
  - Mismatch (in_bit!=p):
    - err_pulse=1 on the next cycle.
    - err_count increments, saturating at all-ones.
    - The window error counter increments.
  - The window bit counter counts valid bits. On wrap at WIN_LEN, both window counters clear.
  - If the window error count reaches LOSS_ERRS:
    - The state moves to HUNT on that bit, and locked falls on the next cycle.
    - Fill and match counters reset to 0, so history must refill before any new comparisons.
- Simultaneous events:
  - clr_cnt together with an error: the clear wins, and err_count = 0 on the next cycle.
  - Loss of lock and window wrap on the same bit: loss wins.
- Latency: every output is registered, one cycle after the sampled bit.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR8_TAPS = 8'hAA and LFSR8_INVERT = 1, also used by the generator so both ends agree.
  - State enum values HUNT and LOCKED.
- One natural sub-module: lfsr_predict, a combinational tap-XOR/XNOR of the history. The generator can reuse it.
- Counters and the state machine stay in the top module.

Test Plan:
- Clean lock:
  - Stimulus: reset, then feed the generator stream (model b[n] = ~(b[n-8]^b[n-6]^b[n-4]^b[n-2]), seed all zeros) continuously.
  - Required: locked=1 exactly 1 cycle after valid bit 24 (8 fill + 16 matches); err_count stays 0 over 1000 bits.
- Single error:
  - Stimulus: once locked, invert one bit.
  - Required: exactly one err_pulse, err_count=1, locked stays 1; errors are not multiplied into the following bits.
- Loss of lock:
  - Stimulus: once locked, invert 8 bits within 64 bits.
  - Required: locked=0 one cycle after the 8th error, err_count=8, re-lock 24 valid bits after a clean stream resumes.
- All-ones input:
  - Stimulus: constant 1 on in_bit.
  - Required: stuck=1 after 8 bits; locked never rises.
- Gaps and clear:
  - Stimulus: pseudo-random in_valid gaps; clr_cnt pulsed on the same cycle as an error.
  - Required: lock timing counts valid bits only; err_count reads 0 after the clear.
- Reset mid-lock:
  - Stimulus: assert rst_n=0 asynchronously while locked.
  - Required: locked, err_count and stuck go to 0 without waiting for a clock edge.
